// File: rtl/uart_cmd_decoder.sv
// 8N1 UART receiver with mid-bit sampling feeding an ASCII switch-command decoder.
// Optional build macro CMD_TERM_EN: commands are held until a CR/LF terminator arrives.
module uart_cmd_decoder #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       UART_RX,
    output logic [1:0] new_state,
    output logic       new_state_arrived,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       rx_busy
);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    logic        r_rx_meta, r_rx_sync;
    logic [1:0]  r_sync_live;
    rx_state_t   r_state, w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_armed, w_armed_nxt;
    logic        r_byte_valid, w_byte_valid_nxt;
    logic        r_frame_err, w_frame_err_nxt;
    logic [1:0]  r_new_state, w_new_state_nxt;
    logic        r_arrived, w_arrived_nxt;
    logic        r_cmd_err, w_cmd_err_nxt;
    logic        w_is_cmd, w_is_term;
    logic [1:0]  w_cmd_val;
`ifdef CMD_TERM_EN
    logic        r_pend_vld, w_pend_vld_nxt;
    logic [1:0]  r_pend_val, w_pend_val_nxt;
`endif

    // r_sync_live keeps the reset value of the synchronizer from counting as a seen idle line
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_sync_live <= 2'b00;
        end else begin
            r_rx_meta   <= UART_RX;
            r_rx_sync   <= r_rx_meta;
            r_sync_live <= {r_sync_live[0], 1'b1};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= 16'd0;
            r_idx        <= 3'd0;
            r_shift      <= 8'd0;
            r_armed      <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_armed      <= w_armed_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer + 16'd1;
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_armed_nxt      = r_armed;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = 16'd0;
                if (r_sync_live[1] && r_rx_sync) w_armed_nxt = 1'b1;
                if (r_armed && !r_rx_sync) begin
                    w_state_nxt = S_START;
                    w_armed_nxt = 1'b0;
                end
            end
            S_START: begin
                if (r_timer == HALF_M1) begin
                    w_timer_nxt = 16'd0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_nxt = 16'd0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_timer == FULL_M1) begin
                    w_byte_valid_nxt = r_rx_sync;
                    w_frame_err_nxt  = !r_rx_sync;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_cmd  = 1'b0;
        w_is_term = 1'b0;
        w_cmd_val = 2'd0;
        case (r_shift)
            8'h30:        w_is_cmd = 1'b1;
            8'h31:        begin w_is_cmd = 1'b1; w_cmd_val = 2'd1; end
            8'h32:        begin w_is_cmd = 1'b1; w_cmd_val = 2'd2; end
            8'h53, 8'h73: begin w_is_cmd = 1'b1; w_cmd_val = 2'd3; end
            8'h0D, 8'h0A: w_is_term = 1'b1;
            default:      ;
        endcase
    end

    always_comb begin
        w_new_state_nxt = r_new_state;
        w_arrived_nxt   = 1'b0;
        w_cmd_err_nxt   = 1'b0;
`ifdef CMD_TERM_EN
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_val_nxt  = r_pend_val;
        if (r_frame_err) w_pend_vld_nxt = 1'b0;
        if (r_byte_valid) begin
            if (w_is_cmd) begin
                // a second command before a terminator poisons both
                w_cmd_err_nxt  = r_pend_vld;
                w_pend_vld_nxt = !r_pend_vld;
                w_pend_val_nxt = w_cmd_val;
            end else if (w_is_term) begin
                if (r_pend_vld) begin
                    w_arrived_nxt   = 1'b1;
                    w_new_state_nxt = r_pend_val;
                end
                w_pend_vld_nxt = 1'b0;
            end else begin
                w_cmd_err_nxt  = 1'b1;
                w_pend_vld_nxt = 1'b0;
            end
        end
`else
        if (r_byte_valid) begin
            if (w_is_cmd) begin
                w_arrived_nxt   = 1'b1;
                w_new_state_nxt = w_cmd_val;
            end else if (!w_is_term) begin
                w_cmd_err_nxt = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_new_state <= 2'd0;
            r_arrived   <= 1'b0;
            r_cmd_err   <= 1'b0;
`ifdef CMD_TERM_EN
            r_pend_vld  <= 1'b0;
            r_pend_val  <= 2'd0;
`endif
        end else begin
            r_new_state <= w_new_state_nxt;
            r_arrived   <= w_arrived_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
`ifdef CMD_TERM_EN
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_val  <= w_pend_val_nxt;
`endif
        end
    end

    assign new_state         = r_new_state;
    assign new_state_arrived = r_arrived;
    assign frame_err         = r_frame_err;
    assign cmd_err           = r_cmd_err;
    assign rx_busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed scenarios plus random frames against a byte-level command model.
module tb_uart_cmd_decoder;
    localparam int N = 16;
    localparam int LAT_OK  = 2 + N/2 + 9*N + 2;
    localparam int LAT_FE  = 2 + N/2 + 9*N + 1;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       UART_RX = 1'b1;
    logic [1:0] new_state;
    logic       new_state_arrived, frame_err, cmd_err, rx_busy;

    uart_cmd_decoder #(.CLKS_PER_BIT(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .UART_RX(UART_RX),
        .new_state(new_state), .new_state_arrived(new_state_arrived),
        .frame_err(frame_err), .cmd_err(cmd_err), .rx_busy(rx_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [2:0] kind; logic [1:0] val; int cyc; } ev_t;
    ev_t obs[$];
    ev_t expq[$];
    int  arr_cyc[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  hold_err = 0;
    logic [1:0] prev_ns = 2'd0;

    // reference model state: last issued command and the one-deep pending slot
    int  m_ns = 0;
    bit  m_pend = 0;
    int  m_pval = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        ev_t e;
        if (new_state_arrived || frame_err || cmd_err) begin
            e.kind = {cmd_err, frame_err, new_state_arrived};
            e.val  = new_state;
            e.cyc  = cyc;
            obs.push_back(e);
            if (new_state_arrived) arr_cyc.push_back(cyc);
        end
        if (Rst_n && !new_state_arrived && new_state !== prev_ns) hold_err++;
        prev_ns = new_state;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cmd_value(input logic [7:0] b);
        if (b == "0") return 0;
        if (b == "1") return 1;
        if (b == "2") return 2;
        if (b == "S" || b == "s") return 3;
        return -1;
    endfunction

    task automatic push_exp(input logic [2:0] k, input int v, input int c);
        ev_t e;
        e.kind = k; e.val = 2'(v); e.cyc = c;
        expq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input int c0);
        int  v;
        bit  term;
        v    = cmd_value(b);
        term = (b == 8'h0D) || (b == 8'h0A);
        if (!ok) begin
            m_pend = 0;
            push_exp(3'b010, 0, c0 + LAT_FE);
            return;
        end
`ifdef CMD_TERM_EN
        if (v >= 0) begin
            if (m_pend) begin m_pend = 0; push_exp(3'b100, 0, c0 + LAT_OK); end
            else begin m_pend = 1; m_pval = v; end
        end else if (term) begin
            if (m_pend) begin m_ns = m_pval; push_exp(3'b001, m_ns, c0 + LAT_OK); end
            m_pend = 0;
        end else begin
            m_pend = 0;
            push_exp(3'b100, 0, c0 + LAT_OK);
        end
`else
        if (v >= 0) begin
            m_ns = v;
            push_exp(3'b001, m_ns, c0 + LAT_OK);
        end else if (!term) begin
            push_exp(3'b100, 0, c0 + LAT_OK);
        end
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit track);
        if (track) model_byte(b, stop_ok, cyc);
        UART_RX = 1'b0;
        repeat (N) @(posedge Clk); #1;
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (N) @(posedge Clk); #1;
        end
        UART_RX = stop_ok;
        repeat (N) @(posedge Clk); #1;
        UART_RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk); #1;
    endtask

    task automatic drain(input string tag);
        int d;
        idle(24);
        chk({tag, "_nevents"}, obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            chk({tag, "_kind"}, obs[i].kind, expq[i].kind);
            if (expq[i].kind == 3'b001) chk({tag, "_state"}, obs[i].val, expq[i].val);
            d = obs[i].cyc - expq[i].cyc;
            chk({tag, "_latency_err"}, (d < -1 || d > 1) ? d : 0, 0);
        end
        obs.delete();
        expq.delete();
    endtask

    initial begin
        int c0;
        logic [7:0] b;
        int r;
        bit ok;

        Rst_n = 1'b0; UART_RX = 1'b1;
        idle(3);
        chk("rst_new_state", new_state, 0);
        chk("rst_arrived", new_state_arrived, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_rx_busy", rx_busy, 0);
        Rst_n = 1'b1;
        idle(6);

        // single '1', with rx_busy profile through the frame
        c0 = cyc;
        fork
            send_frame(8'h31, 1'b1, 1'b1);
            begin
                idle(1);   chk("busy_before_start", rx_busy, 0);
                idle(19);  chk("busy_data", rx_busy, 1);
                idle(130); chk("busy_stop", rx_busy, 1);
            end
        join
        chk("busy_after_frame", rx_busy, 0);
        drain("one");
        chk("one_final_state", new_state, 1);

        // back-to-back 'S' 's'
        arr_cyc.delete();
        send_frame("S", 1'b1, 1'b1);
        send_frame("s", 1'b1, 1'b1);
        drain("b2b");
        chk("b2b_pulses", arr_cyc.size(), 2);
        if (arr_cyc.size() == 2) chk("b2b_spacing", arr_cyc[1] - arr_cyc[0], 10 * N);

        // 5-cycle glitch on idle line
        UART_RX = 1'b0;
        idle(5);
        chk("glitch_busy", rx_busy, 1);
        UART_RX = 1'b1;
        idle(8);
        chk("glitch_back_idle", rx_busy, 0);
        drain("glitch");

        // framing error on '2'
        send_frame(8'h32, 1'b0, 1'b1);
        idle(10);
        drain("frame");
        chk("frame_state_kept", new_state, 3);

        // reset during data bit 4; bits 4..7 of 0x0F are low so the line stays low after release
        fork
            send_frame(8'h0F, 1'b1, 1'b0);
            begin
                idle(5 * N + 8);
                Rst_n = 1'b0;
                #1;
                chk("midrst_new_state", new_state, 0);
                chk("midrst_busy", rx_busy, 0);
                idle(3);
                Rst_n = 1'b1;
                m_ns = 0; m_pend = 0;
            end
        join
        drain("midrst");
        send_frame(8'h31, 1'b1, 1'b1);
`ifdef CMD_TERM_EN
        send_frame(8'h0D, 1'b1, 1'b1);
`endif
        drain("after_rst");

        // invalid byte then '0'
        send_frame("x", 1'b1, 1'b1);
        send_frame("0", 1'b1, 1'b1);
        drain("inval");
        chk("inval_state", new_state, m_ns);

        // terminator sequences
        send_frame("2", 1'b1, 1'b1);
        send_frame(8'h0D, 1'b1, 1'b1);
        send_frame(8'h0A, 1'b1, 1'b1);
        drain("crlf");
        chk("crlf_state", new_state, 2);
        send_frame("1", 1'b1, 1'b1);
        send_frame("2", 1'b1, 1'b1);
        send_frame(8'h0D, 1'b1, 1'b1);
        drain("double");
        chk("double_state", new_state, m_ns);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = "0";
                1: b = "1";
                2: b = "2";
                3: b = "S";
                4: b = "s";
                5: b = 8'h0D;
                6: b = 8'h0A;
                default: b = 8'($urandom_range(0, 255));
            endcase
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, 1'b1);
            if (!ok) idle($urandom_range(8, 30));
            else if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 30));
        end
        drain("rand");
        chk("rand_final_state", new_state, m_ns);
        chk("state_hold_violations", hold_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
